// File: rtl/psum_pkg.sv
// rtl/psum_pkg.sv - shared sizing and saturation helpers for the psum adder tree
package psum_pkg;

    typedef enum logic [1:0] {
        SAT_NONE = 2'b00,
        SAT_HIGH = 2'b01,
        SAT_LOW  = 2'b10
    } sat_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int tree_stages(input int num_pe);
        return clog2(num_pe);
    endfunction

    function automatic int guard_bits(input int num_pe);
        return clog2(num_pe + 1);
    endfunction

    // Operand count present after 'lvl' pairwise reductions of num_pe inputs.
    function automatic int level_count(input int num_pe, input int lvl);
        return (num_pe + (1 << lvl) - 1) >> lvl;
    endfunction

    // Classifies a wide signed value against the signed range of 'width' bits.
    function automatic sat_e sat_check(input logic signed [63:0] val, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (val > hi) return SAT_HIGH;
        if (val < lo) return SAT_LOW;
        return SAT_NONE;
    endfunction

endpackage

// File: rtl/psum_tree_level.sv
// rtl/psum_tree_level.sv - one registered pairwise-add level of the psum adder tree
module psum_tree_level #(
    parameter int N_IN  = 3,
    parameter int WIDTH = 27
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                stall,
    input  logic [N_IN*WIDTH-1:0]               d,
    input  logic                                first_d,
    input  logic                                last_d,
    output logic [((N_IN+1)/2)*WIDTH-1:0]       q,
    output logic                                first_q,
    output logic                                last_q
);

    localparam int N_OUT = (N_IN + 1) / 2;

    logic [N_OUT*WIDTH-1:0] sums;

    // Guard bits upstream make the truncating add exact.
    for (genvar i = 0; i < N_IN / 2; i++) begin : g_pair
        assign sums[i*WIDTH +: WIDTH] = d[2*i*WIDTH +: WIDTH] + d[(2*i+1)*WIDTH +: WIDTH];
    end

    if (N_IN % 2 == 1) begin : g_odd
        assign sums[(N_OUT-1)*WIDTH +: WIDTH] = d[(N_IN-1)*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (!stall) begin
            q       <= sums;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: rtl/psum_add_tree.sv
// rtl/psum_add_tree.sv - pipelined PE adder tree with psum accumulate, saturation and ReLU
module psum_add_tree
    import psum_pkg::*;
#(
    parameter int DATA_WIDTH = 25,
    parameter int NUM_PE     = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         clear,
    input  logic                         in_valid,
    input  logic                         in_first,
    input  logic                         in_last,
    input  logic [NUM_PE*DATA_WIDTH-1:0] pe_data,
    input  logic [DATA_WIDTH-1:0]        fifo_data,
    input  logic                         sat_en,
    input  logic                         relu_en,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    output logic                         out_last
);

    localparam int TREE_STAGES = tree_stages(NUM_PE);
    localparam int GUARD       = guard_bits(NUM_PE);
    localparam int IW          = DATA_WIDTH + GUARD;
    localparam int AW          = IW + 1;

    for (genvar k = 0; k <= TREE_STAGES; k++) begin : g_lvl
        localparam int N = level_count(NUM_PE, k);
        logic [N*IW-1:0] d;
        logic            first;
        logic            last;

        if (k == 0) begin : g_in
            for (genvar i = 0; i < NUM_PE; i++) begin : g_sext
                assign d[i*IW +: IW] = {{GUARD{pe_data[i*DATA_WIDTH+DATA_WIDTH-1]}},
                                        pe_data[i*DATA_WIDTH +: DATA_WIDTH]};
            end
            assign first = in_first;
            assign last  = in_last;
        end else begin : g_reg
            psum_tree_level #(
                .N_IN  (level_count(NUM_PE, k - 1)),
                .WIDTH (IW)
            ) u_level (
                .clk     (clk),
                .rst     (rst),
                .stall   (stall),
                .d       (g_lvl[k-1].d),
                .first_d (g_lvl[k-1].first),
                .last_d  (g_lvl[k-1].last),
                .q       (d),
                .first_q (first),
                .last_q  (last)
            );
        end
    end

    logic [IW-1:0]           tree_sum;
    logic                    tree_first;
    logic                    tree_last;
    logic [AW-1:0]           fifo_ext;
    logic [AW-1:0]           acc;
    logic signed [63:0]      acc_wide;
    logic [DATA_WIDTH-1:0]   result;
    logic [TREE_STAGES-1:0]  vld;

    assign tree_sum   = g_lvl[TREE_STAGES].d;
    assign tree_first = g_lvl[TREE_STAGES].first;
    assign tree_last  = g_lvl[TREE_STAGES].last;

    assign fifo_ext = tree_first ? '0
                    : {{(AW-DATA_WIDTH){fifo_data[DATA_WIDTH-1]}}, fifo_data};
    assign acc      = {tree_sum[IW-1], tree_sum} + fifo_ext;
    assign acc_wide = {{(64-AW){acc[AW-1]}}, acc};

    always_comb begin
        result = acc[DATA_WIDTH-1:0];
        if (sat_en) begin
            case (sat_check(acc_wide, DATA_WIDTH))
                SAT_HIGH: result = {1'b0, {(DATA_WIDTH-1){1'b1}}};
                SAT_LOW:  result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
                default:  result = acc[DATA_WIDTH-1:0];
            endcase
        end
        if (relu_en && tree_last && result[DATA_WIDTH-1]) begin
            result = '0;
        end
    end

    // clear beats stall on the valid chain only; data registers simply follow stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (clear) begin
                vld       <= '0;
                out_valid <= 1'b0;
            end else if (!stall) begin
                vld[0] <= in_valid;
                for (int i = 1; i < TREE_STAGES; i++) begin
                    vld[i] <= vld[i-1];
                end
                out_valid <= vld[TREE_STAGES-1];
            end
            if (!stall) begin
                out_data <= result;
                out_last <= tree_last;
            end
        end
    end

endmodule

// File: tb/tb_psum_add_tree.sv
// tb/tb_psum_add_tree.sv - self-checking bench for psum_add_tree
module tb_psum_add_tree;

    localparam int DW = 25;
    localparam int NP = 3;
    localparam int TS = 2;
    localparam longint MAXV = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (DW - 1));

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            stall = 1'b0;
    logic            clear = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_first = 1'b0;
    logic            in_last = 1'b0;
    logic [NP*DW-1:0] pe_data = '0;
    logic [DW-1:0]   fifo_data = '0;
    logic            sat_en = 1'b1;
    logic            relu_en = 1'b0;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_last;

    int vectors = 0;
    int miscompares = 0;

    psum_add_tree #(.DATA_WIDTH(DW), .NUM_PE(NP)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_last   (in_last),
        .pe_data   (pe_data),
        .fifo_data (fifo_data),
        .sat_en    (sat_en),
        .relu_en   (relu_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint sum;
        bit     first;
        bit     last;
        int     age;
    } item_t;

    item_t  mq[$];
    bit     exp_valid = 1'b0;
    longint exp_data = 0;
    bit     exp_last = 1'b0;

    function automatic longint calc(input longint s, input longint f, input bit fst,
                                    input bit lst, input bit sat, input bit relu);
        longint acc;
        longint r;
        acc = s + (fst ? 0 : f);
        if (sat) begin
            r = (acc > MAXV) ? MAXV : ((acc < MINV) ? MINV : acc);
        end else begin
            r = acc & ((longint'(1) <<< DW) - 1);
            if (r > MAXV) r = r - (longint'(1) <<< DW);
        end
        if (relu && lst && r < 0) r = 0;
        return r;
    endfunction

    function automatic longint pe_sum(input logic [NP*DW-1:0] p);
        longint s = 0;
        for (int i = 0; i < NP; i++) begin
            logic [DW-1:0] v;
            v = p[i*DW +: DW];
            s += longint'($signed(v));
        end
        return s;
    endfunction

    // Latency-queue reference: an accepted input emerges on its (TS+1)-th unstalled edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            exp_valid = 1'b0;
            exp_data  = 0;
            exp_last  = 1'b0;
        end else if (clear) begin
            mq.delete();
            exp_valid = 1'b0;
        end else if (!stall) begin
            item_t it;
            exp_valid = 1'b0;
            if (mq.size() > 0 && mq[0].age == TS) begin
                it = mq.pop_front();
                exp_valid = 1'b1;
                exp_data  = calc(it.sum, longint'($signed(fifo_data)), it.first, it.last,
                                 sat_en, relu_en);
                exp_last  = it.last;
            end
            foreach (mq[i]) mq[i].age++;
            if (in_valid) begin
                it.sum = pe_sum(pe_data);
                it.first = in_first;
                it.last = in_last;
                it.age = 1;
                mq.push_back(it);
            end
        end
    end

    task automatic check(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    bit     stall_at;
    int     edge_cnt = 0;
    bit     cap_en = 1'b0;
    longint cap_data[$];
    int     cap_edge[$];

    task automatic cycle();
        @(posedge clk);
        stall_at = stall;
        edge_cnt++;
        @(negedge clk);
        if (rst) begin
            check("rst_out", {out_valid, out_last, out_data}, 0);
        end else begin
            check("model_valid", out_valid, exp_valid);
            if (exp_valid) begin
                check("model_data", longint'($signed(out_data)), exp_data);
                check("model_last", out_last, exp_last);
            end
        end
        if (cap_en && out_valid && !stall_at) begin
            cap_data.push_back(longint'($signed(out_data)));
            cap_edge.push_back(edge_cnt);
        end
    endtask

    task automatic set_pe(input int a, input int b, input int c);
        pe_data = {DW'(c), DW'(b), DW'(a)};
    endtask

    task automatic run_one(input string nm, input int a, input int b, input int c, input int f,
                           input bit fst, input bit lst, input longint exp_d, input bit exp_l);
        int lat;
        bit seen;
        set_pe(a, b, c);
        fifo_data = DW'(f);
        in_first = fst;
        in_last = lst;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        lat = 1;
        seen = 1'b0;
        while (!seen && lat < 8) begin
            cycle();
            lat++;
            if (out_valid) seen = 1'b1;
        end
        check({nm, "_latency"}, seen ? lat : -1, 3);
        check({nm, "_data"}, longint'($signed(out_data)), exp_d);
        check({nm, "_last"}, out_last, exp_l);
        cycle();
    endtask

    task automatic count_valids(input string nm, input int n);
        int seen_v = 0;
        for (int i = 0; i < n; i++) begin
            cycle();
            if (out_valid) seen_v++;
        end
        check(nm, seen_v, 0);
    endtask

    function automatic logic [DW-1:0] rnd_val();
        int unsigned r;
        r = $urandom_range(0, 7);
        if (r == 0) return DW'(MAXV);
        if (r == 1) return DW'(MINV);
        return DW'($urandom);
    endfunction

    initial begin
        repeat (3) cycle();
        check("rst_data_zero", out_data, 0);
        rst = 1'b0;
        cycle();

        sat_en = 1'b1; relu_en = 1'b0;
        run_one("basic", 10, 20, -5, 100, 1'b0, 1'b0, 125, 1'b0);
        run_one("first", 1, 2, 3, 999, 1'b1, 1'b0, 6, 1'b0);
        run_one("ovf_sat", 16777215, 16777215, 16777215, 16777215, 1'b0, 1'b0, 16777215, 1'b0);
        sat_en = 1'b0;
        run_one("ovf_wrap", 16777215, 16777215, 16777215, 16777215, 1'b0, 1'b0, -4, 1'b0);
        sat_en = 1'b1; relu_en = 1'b1;
        run_one("relu_last", -50, 0, 0, 10, 1'b0, 1'b1, 0, 1'b1);
        run_one("relu_nolast", -50, 0, 0, 10, 1'b0, 1'b0, -40, 1'b0);
        relu_en = 1'b0;

        // Five results through a 2-cycle mid-stream stall.
        cap_en = 1'b1;
        cap_data.delete();
        cap_edge.delete();
        begin
            int e0;
            e0 = edge_cnt + 1;
            for (int k = 1; k <= 5; k++) begin
                if (k == 4) begin
                    stall = 1'b1;
                    in_valid = 1'b0;
                    cycle();
                    cycle();
                    stall = 1'b0;
                end
                set_pe(k, 0, 0);
                fifo_data = DW'(777);
                in_first = 1'b1;
                in_last = 1'b0;
                in_valid = 1'b1;
                cycle();
            end
            in_valid = 1'b0;
            repeat (6) cycle();
            cap_en = 1'b0;
            check("stall_count", cap_data.size(), 5);
            for (int k = 0; k < 5 && k < cap_data.size(); k++) begin
                check("stall_order", cap_data[k], k + 1);
            end
            if (cap_edge.size() == 5) begin
                check("stall_first_edge", cap_edge[0] - e0, 2);
                check("stall_last_edge", cap_edge[4] - e0, 8);
            end
        end

        // Clear with two inputs in flight and a third presented alongside it.
        set_pe(7, 8, 9);
        in_first = 1'b1;
        in_valid = 1'b1;
        cycle();
        cycle();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        in_valid = 1'b0;
        count_valids("clear_no_out", 6);
        run_one("after_clear", 4, 5, 6, 1, 1'b0, 1'b1, 16, 1'b1);

        // Asynchronous reset mid-stream.
        set_pe(11, 12, 13);
        in_first = 1'b0;
        in_valid = 1'b1;
        cycle();
        cycle();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_data", out_data, 0);
        check("async_rst_last", out_last, 0);
        cycle();
        rst = 1'b0;
        count_valids("rst_no_out", 6);
        run_one("after_rst", -1, -2, -3, 10, 1'b0, 1'b0, 4, 1'b0);

        // Randomised traffic; sat/relu only change while the pipeline is idle.
        for (int b = 0; b < 4; b++) begin
            sat_en = b[0];
            relu_en = b[1];
            for (int n = 0; n < 300; n++) begin
                set_pe(int'($signed(rnd_val())), int'($signed(rnd_val())), int'($signed(rnd_val())));
                fifo_data = rnd_val();
                in_valid = ($urandom_range(0, 3) != 0);
                in_first = ($urandom_range(0, 3) == 0);
                in_last = ($urandom_range(0, 1) == 0);
                stall = ($urandom_range(0, 6) == 0);
                clear = ($urandom_range(0, 40) == 0);
                cycle();
            end
            in_valid = 1'b0;
            stall = 1'b0;
            clear = 1'b0;
            repeat (6) cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
